aq_vfmau_mult_round: RTL and testbench

//  EX3/EX4 stage directly downstream of the vfmau fraction multiplier.
//  - Consumes the 106-bit product ex2_mult_data plus sign/exponent/format/rounding-mode sideband.
//  - Normalizes by at most 1 bit, rounds to the target format precision and flags inexact.
//  - Delivers a left-aligned rounded significand and adjusted exponent in EX4 for packing/exception logic.

---
 rtl/aq_vfmau_mult_round_if.sv | 63 ++++++
 rtl/aq_vfmau_mult_round.sv | 217 +++++++++++++++++++++
 tb/tb_aq_vfmau_mult_round.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_vfmau_mult_round_if.sv
// Bundle of EX2 inputs, pipeline control and EX4 result outputs for the
// vfmau multiplier round stage.
// Optional feature macro: AQ_VFMAU_FMA_RAW_OUT_EN adds the raw EX3 product
// outputs used by the fused-add path.
interface aq_vfmau_mult_round_if #(
    parameter int unsigned PROD_W = 106,
    parameter int unsigned FRAC_W = 53,
    parameter int unsigned EXPN_W = 13
);
    // EX2 operand and sideband
    logic [PROD_W-1:0] ex2_mult_data;
    logic              ex2_sign;
    logic [EXPN_W-1:0] ex2_expnt;
    logic              ex2_double;
    logic              ex2_single;
    logic              ex2_f16;
    logic              ex2_bf16;
    logic [2:0]        ex2_rm;

    // pipeline control
    logic              ctrl_dp_ex2_inst_pipe_down;
    logic              ctrl_ex4_stall;
    logic              rtu_vpu_flush;
    logic              ex3_accept;

    // EX4 result
    logic              ex4_vld;
    logic              ex4_sign;
    logic [FRAC_W-1:0] ex4_frac;
    logic [EXPN_W-1:0] ex4_expnt;
    logic              ex4_nx;

`ifdef AQ_VFMAU_FMA_RAW_OUT_EN
    logic              ex3_raw_vld;
    logic [PROD_W-1:0] ex3_raw_prod;
`endif

    // upstream/downstream side: drives operands and control, observes results
    modport master (
        output ex2_mult_data, ex2_sign, ex2_expnt,
        output ex2_double, ex2_single, ex2_f16, ex2_bf16, ex2_rm,
        output ctrl_dp_ex2_inst_pipe_down, ctrl_ex4_stall, rtu_vpu_flush,
        input  ex3_accept,
        input  ex4_vld, ex4_sign, ex4_frac, ex4_expnt, ex4_nx
`ifdef AQ_VFMAU_FMA_RAW_OUT_EN
        ,
        input  ex3_raw_vld, ex3_raw_prod
`endif
    );

    // round stage side
    modport slave (
        input  ex2_mult_data, ex2_sign, ex2_expnt,
        input  ex2_double, ex2_single, ex2_f16, ex2_bf16, ex2_rm,
        input  ctrl_dp_ex2_inst_pipe_down, ctrl_ex4_stall, rtu_vpu_flush,
        output ex3_accept,
        output ex4_vld, ex4_sign, ex4_frac, ex4_expnt, ex4_nx
`ifdef AQ_VFMAU_FMA_RAW_OUT_EN
        ,
        output ex3_raw_vld, ex3_raw_prod
`endif
    );
endinterface

// File: rtl/aq_vfmau_mult_round.sv
// EX3/EX4 stage after the vfmau fraction multiplier: captures the 106-bit
// product in EX3, normalizes by at most one bit, rounds to the target format
// precision and registers a left-aligned significand, exponent and inexact
// flag in EX4.
// Optional feature macro: AQ_VFMAU_FMA_RAW_OUT_EN exposes the unrounded EX3
// product and its valid for the fused-add path.
module aq_vfmau_mult_round #(
    parameter int unsigned PROD_W = 106,
    parameter int unsigned FRAC_W = 53,
    parameter int unsigned EXPN_W = 13
) (
    input logic                  forever_cpuclk,
    input logic                  cpurst,
    aq_vfmau_mult_round_if.slave bus
);

    localparam int unsigned REST_W = PROD_W - FRAC_W;
    localparam int unsigned DROP_W = $clog2(FRAC_W);

    // bits dropped below the kept field, per format
    localparam logic [DROP_W-1:0] DROP_D  = DROP_W'(0);
    localparam logic [DROP_W-1:0] DROP_S  = DROP_W'(FRAC_W - 24);
    localparam logic [DROP_W-1:0] DROP_H  = DROP_W'(FRAC_W - 11);
    localparam logic [DROP_W-1:0] DROP_BF = DROP_W'(FRAC_W - 8);

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // EX3 state
    logic              ex3_vld_q, ex3_vld_d;
    logic [PROD_W-1:0] ex3_prod_q;
    logic              ex3_sign_q;
    logic [EXPN_W-1:0] ex3_expnt_q;
    logic [3:0]        ex3_fmt_q;
    logic [2:0]        ex3_rm_q;

    // EX4 state
    logic              ex4_vld_q, ex4_vld_d;
    logic              ex4_sign_q;
    logic [FRAC_W-1:0] ex4_frac_q;
    logic [EXPN_W-1:0] ex4_expnt_q;
    logic              ex4_nx_q;

    // EX3 datapath
    logic              norm_sh;
    logic [PROD_W-1:0] norm;
    logic [FRAC_W-1:0] mant;
    logic [REST_W-1:0] rest;
    logic [DROP_W-1:0] drop;
    logic [FRAC_W-1:0] lsb_unit;
    logic [FRAC_W-1:0] low_mask;
    logic [FRAC_W-1:0] kept;
    logic              rnd_lsb;
    logic              rnd_g;
    logic              rnd_s;
    logic              rnd_inc;
    logic [FRAC_W:0]   rnd_sum;
    logic              rnd_carry;
    logic [FRAC_W-1:0] ex3_frac;
    logic [EXPN_W-1:0] ex3_expnt_rnd;
    logic              ex3_nx;

    logic pipe_down;
    logic stall;
    logic flush;
    logic ex4_load;

    assign pipe_down = bus.ctrl_dp_ex2_inst_pipe_down;
    assign stall     = bus.ctrl_ex4_stall;
    assign flush     = bus.rtu_vpu_flush;

    // EX3 hands its op to EX4 when EX4 is empty or being drained this cycle
    assign ex4_load       = ex3_vld_q & (~ex4_vld_q | ~stall);
    assign bus.ex3_accept = ~ex3_vld_q | ~stall | ~ex4_vld_q;

    // Normalize by one bit, then split into kept significand and lower bits
    always_comb begin
        norm_sh = ex3_prod_q[PROD_W-1];
        norm    = norm_sh ? ex3_prod_q : (ex3_prod_q << 1);
        mant    = norm[PROD_W-1 -: FRAC_W];
        rest    = norm[REST_W-1:0];
    end

    // Select how many significand bits the target format discards
    always_comb begin
        drop = DROP_D;
        unique case ({ex3_fmt_q[3], ex3_fmt_q[2], ex3_fmt_q[1], ex3_fmt_q[0]})
            4'b1000: drop = DROP_D;
            4'b0100: drop = DROP_S;
            4'b0010: drop = DROP_H;
            4'b0001: drop = DROP_BF;
            default: drop = DROP_D;
        endcase
    end

    // Derive lsb/guard/sticky and the rounding increment
    always_comb begin
        lsb_unit = {{(FRAC_W-1){1'b0}}, 1'b1} << drop;
        low_mask = lsb_unit - {{(FRAC_W-1){1'b0}}, 1'b1};
        kept     = mant & ~low_mask;
        rnd_lsb  = |(mant & lsb_unit);
        if (drop == DROP_D) begin
            // double keeps all of mant; guard is the top product bit below it
            rnd_g = rest[REST_W-1];
            rnd_s = |rest[REST_W-2:0];
        end else begin
            rnd_g = |(mant & (lsb_unit >> 1));
            rnd_s = (|(mant & (low_mask >> 1))) | (|rest);
        end

        rnd_inc = 1'b0;
        case (ex3_rm_q)
            RM_RNE:  rnd_inc = rnd_g & (rnd_s | rnd_lsb);
            RM_RTZ:  rnd_inc = 1'b0;
            RM_RDN:  rnd_inc = ex3_sign_q & (rnd_g | rnd_s);
            RM_RUP:  rnd_inc = ~ex3_sign_q & (rnd_g | rnd_s);
            RM_RMM:  rnd_inc = rnd_g;
            default: rnd_inc = rnd_g & (rnd_s | rnd_lsb);
        endcase
    end

    // Apply the increment; a carry out renormalizes to 1.000..0
    always_comb begin
        rnd_sum   = {1'b0, kept} + {1'b0, (rnd_inc ? lsb_unit : {FRAC_W{1'b0}})};
        rnd_carry = rnd_sum[FRAC_W];
        ex3_frac  = rnd_carry ? {1'b1, {(FRAC_W-1){1'b0}}} : rnd_sum[FRAC_W-1:0];
        // exponent wraps; range checking happens downstream
        ex3_expnt_rnd = ex3_expnt_q + EXPN_W'(norm_sh) + EXPN_W'(rnd_carry);
        ex3_nx        = rnd_g | rnd_s;
    end

    // Valid next-state: flush wins over capture and hand-off
    always_comb begin
        ex3_vld_d = ex3_vld_q;
        ex4_vld_d = ex4_vld_q;
        if (pipe_down) begin
            ex3_vld_d = 1'b1;
        end else if (ex4_load) begin
            ex3_vld_d = 1'b0;
        end
        if (ex4_load) begin
            ex4_vld_d = 1'b1;
        end else if (!stall) begin
            ex4_vld_d = 1'b0;
        end
        if (flush) begin
            ex3_vld_d = 1'b0;
            ex4_vld_d = 1'b0;
        end
    end

    // Valid registers
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ex3_vld_q <= 1'b0;
            ex4_vld_q <= 1'b0;
        end else begin
            ex3_vld_q <= ex3_vld_d;
            ex4_vld_q <= ex4_vld_d;
        end
    end

    // EX3 capture of product and sideband on pipe_down
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ex3_prod_q  <= '0;
            ex3_sign_q  <= 1'b0;
            ex3_expnt_q <= '0;
            ex3_fmt_q   <= '0;
            ex3_rm_q    <= '0;
        end else if (pipe_down) begin
            ex3_prod_q  <= bus.ex2_mult_data;
            ex3_sign_q  <= bus.ex2_sign;
            ex3_expnt_q <= bus.ex2_expnt;
            ex3_fmt_q   <= {bus.ex2_double, bus.ex2_single, bus.ex2_f16, bus.ex2_bf16};
            ex3_rm_q    <= bus.ex2_rm;
        end
    end

    // EX4 result register, held while the consumer stalls
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ex4_sign_q  <= 1'b0;
            ex4_frac_q  <= '0;
            ex4_expnt_q <= '0;
            ex4_nx_q    <= 1'b0;
        end else if (ex4_load) begin
            ex4_sign_q  <= ex3_sign_q;
            ex4_frac_q  <= ex3_frac;
            ex4_expnt_q <= ex3_expnt_rnd;
            ex4_nx_q    <= ex3_nx;
        end
    end

    assign bus.ex4_vld   = ex4_vld_q;
    assign bus.ex4_sign  = ex4_sign_q;
    assign bus.ex4_frac  = ex4_frac_q;
    assign bus.ex4_expnt = ex4_expnt_q;
    assign bus.ex4_nx    = ex4_nx_q;

`ifdef AQ_VFMAU_FMA_RAW_OUT_EN
    assign bus.ex3_raw_vld  = ex3_vld_q & ~flush;
    assign bus.ex3_raw_prod = ex3_prod_q;
`endif

`ifndef SYNTHESIS
    // upstream must never advance into a full, blocked EX3
    a_no_pipe_down_when_full: assert property (
        @(posedge forever_cpuclk) disable iff (cpurst)
        !(pipe_down && !bus.ex3_accept)
    );
`endif

endmodule

// File: tb/tb_aq_vfmau_mult_round.sv
module tb_aq_vfmau_mult_round;

    typedef struct packed {
        logic        sign;
        logic [52:0] frac;
        logic [12:0] expnt;
        logic        nx;
    } res_t;

    typedef struct {
        logic [105:0] prod;
        logic         sign;
        logic [12:0]  expnt;
        logic [3:0]   fmt;
        logic [2:0]   rm;
        logic [52:0]  frac;
        logic [12:0]  eexp;
        logic         nx;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   sb_en;
    res_t exp_q[$];

    aq_vfmau_mult_round_if bus ();

    aq_vfmau_mult_round dut (
        .forever_cpuclk(clk),
        .cpurst        (rst),
        .bus           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [105:0] bit_at(input int i);
        logic [105:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Integer-arithmetic reference: quotient/remainder by a power of two
    function automatic res_t ref_round(input logic [105:0] p, input logic sg,
                                       input logic [12:0] e, input logic [3:0] fmt,
                                       input logic [2:0] rm);
        res_t         r;
        int           keep;
        int           total;
        logic [106:0] pp, q, rem, half;
        logic         g, s, inc;
        keep = fmt[3] ? 53 : fmt[2] ? 24 : fmt[1] ? 11 : fmt[0] ? 8 : 53;
        r.expnt = e;
        if (p[105]) r.expnt = e + 13'd1;
        total = (p[105] ? 53 : 52) + (53 - keep);
        pp    = {1'b0, p};
        q     = pp >> total;
        rem   = pp - (q << total);
        half  = 107'(1) << (total - 1);
        g     = (rem >= half);
        s     = g ? (rem != half) : (rem != 0);
        case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = sg & (g | s);
            3'd3:    inc = !sg & (g | s);
            3'd4:    inc = g;
            default: inc = g & (s | q[0]);
        endcase
        q = q + 107'(inc);
        if (q == (107'(1) << keep)) begin
            q       = q >> 1;
            r.expnt = r.expnt + 13'd1;
        end
        r.frac = 53'(q << (53 - keep));
        r.nx   = g | s;
        r.sign = sg;
        return r;
    endfunction

    task automatic set_op(input logic [105:0] p, input logic sg, input logic [12:0] e,
                          input logic [3:0] fmt, input logic [2:0] rm);
        bus.ex2_mult_data = p;
        bus.ex2_sign      = sg;
        bus.ex2_expnt     = e;
        {bus.ex2_double, bus.ex2_single, bus.ex2_f16, bus.ex2_bf16} = fmt;
        bus.ex2_rm        = rm;
    endtask

    task automatic rand_op();
        logic [105:0] p;
        logic [105:0] m;
        p = 106'({$urandom(), $urandom(), $urandom(), $urandom()});
        case ($urandom_range(0, 5))
            0: p = '0;
            1: begin
                m = (106'(1) << $urandom_range(20, 100)) - 106'(1);
                p = p & ~m;
            end
            2: begin
                m = (106'(1) << $urandom_range(50, 100)) - 106'(1);
                p = p | ~m;
            end
            default: ;
        endcase
        if (p != 0 && !p[105]) p[104] = 1'b1;
        set_op(p, 1'($urandom_range(0, 1)), 13'($urandom()),
               4'(4'b1000 >> $urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    endtask

    // Scoreboard: consumer takes EX4 when valid and not stalled
    always @(negedge clk) begin
        if (sb_en) begin
            if (bus.ex4_vld && !bus.ctrl_ex4_stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got result %0h expected none", bus.ex4_frac);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("sb_frac", bus.ex4_frac, e.frac);
                    chk("sb_expnt", bus.ex4_expnt, e.expnt);
                    chk("sb_nx", bus.ex4_nx, e.nx);
                    chk("sb_sign", bus.ex4_sign, e.sign);
                end
            end
            if (bus.rtu_vpu_flush) exp_q.delete();
            else if (bus.ctrl_dp_ex2_inst_pipe_down)
                exp_q.push_back(ref_round(bus.ex2_mult_data, bus.ex2_sign, bus.ex2_expnt,
                    {bus.ex2_double, bus.ex2_single, bus.ex2_f16, bus.ex2_bf16}, bus.ex2_rm));
        end
    end

    initial begin
        vec_t         vecs[12];
        logic [105:0] p;
        logic [12:0]  got[$];
        int           issued, stall_left, zero_acc;
        bit           stall_started;

        checks = 0;
        errors = 0;
        sb_en  = 1'b0;
        rst    = 1'b1;
        set_op('0, 1'b0, '0, 4'b1000, 3'd0);
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
        bus.ctrl_ex4_stall             = 1'b0;
        bus.rtu_vpu_flush              = 1'b0;

        // ---- vector table ----
        vecs[0] = '{bit_at(105) | bit_at(102), 1'b0, 13'h3FF, 4'b1000, 3'd0,
                    53'h12000000000000, 13'h400, 1'b0};
        p = '0;
        for (int i = 80; i <= 104; i++) p[i] = 1'b1;
        vecs[1] = '{p, 1'b0, 13'h080, 4'b0100, 3'd0, 53'h10000000000000, 13'h081, 1'b1};
        vecs[2] = '{bit_at(104) | bit_at(80), 1'b1, 13'h100, 4'b0100, 3'd0,
                    53'h10000000000000, 13'h100, 1'b1};
        vecs[3] = '{bit_at(104) | bit_at(80), 1'b1, 13'h100, 4'b0100, 3'd1,
                    53'h10000000000000, 13'h100, 1'b1};
        vecs[4] = '{bit_at(104) | bit_at(80), 1'b1, 13'h100, 4'b0100, 3'd2,
                    53'h10000020000000, 13'h100, 1'b1};
        vecs[5] = '{bit_at(104) | bit_at(80), 1'b1, 13'h100, 4'b0100, 3'd3,
                    53'h10000000000000, 13'h100, 1'b1};
        vecs[6] = '{bit_at(104) | bit_at(80), 1'b1, 13'h100, 4'b0100, 3'd4,
                    53'h10000020000000, 13'h100, 1'b1};
        vecs[7] = '{106'd0, 1'b1, 13'h055, 4'b0001, 3'd2, 53'h0, 13'h055, 1'b0};
        vecs[8] = '{bit_at(105) | bit_at(0), 1'b0, 13'h1FFF, 4'b1000, 3'd3,
                    53'h10000000000001, 13'h0000, 1'b1};
        vecs[9] = '{bit_at(104) | bit_at(97) | bit_at(96), 1'b0, 13'h200, 4'b0001, 3'd5,
                    53'h10400000000000, 13'h200, 1'b1};
        vecs[10] = '{bit_at(105) | bit_at(60), 1'b0, 13'h010, 4'b0010, 3'd2,
                     53'h10000000000000, 13'h011, 1'b1};
        p = '1;
        vecs[11] = '{p, 1'b0, 13'h0FF, 4'b0010, 3'd3, 53'h10000000000000, 13'h101, 1'b1};

        // ---- reset state ----
        tick();
        tick();
        rst = 1'b0;
        chk("rst_vld", bus.ex4_vld, 1'b0);
        chk("rst_frac", bus.ex4_frac, 53'h0);
        chk("rst_expnt", bus.ex4_expnt, 13'h0);
        chk("rst_nx", bus.ex4_nx, 1'b0);
        chk("rst_sign", bus.ex4_sign, 1'b0);
        chk("rst_accept", bus.ex3_accept, 1'b1);

        // ---- table-driven rounding vectors ----
        foreach (vecs[i]) begin
            set_op(vecs[i].prod, vecs[i].sign, vecs[i].expnt, vecs[i].fmt, vecs[i].rm);
            bus.ctrl_dp_ex2_inst_pipe_down = 1'b1;
            tick();
            bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
            chk($sformatf("v%0d_vld_n1", i), bus.ex4_vld, 1'b0);
            tick();
            chk($sformatf("v%0d_vld", i), bus.ex4_vld, 1'b1);
            chk($sformatf("v%0d_frac", i), bus.ex4_frac, vecs[i].frac);
            chk($sformatf("v%0d_expnt", i), bus.ex4_expnt, vecs[i].eexp);
            chk($sformatf("v%0d_nx", i), bus.ex4_nx, vecs[i].nx);
            chk($sformatf("v%0d_sign", i), bus.ex4_sign, vecs[i].sign);
            tick();
            chk($sformatf("v%0d_vld_clr", i), bus.ex4_vld, 1'b0);
        end

        // ---- back-to-back 4 ops with a 3-cycle stall on op1 ----
        issued        = 0;
        stall_left    = 0;
        zero_acc      = 0;
        stall_started = 0;
        for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
            if (!stall_started && bus.ex4_vld) begin
                stall_started = 1;
                stall_left    = 3;
            end
            bus.ctrl_ex4_stall = (stall_left > 0);
            #1;
            if (bus.ctrl_ex4_stall) begin
                if (!bus.ex3_accept) zero_acc++;
                chk("b2b_hold", bus.ex4_expnt, 13'h301);
            end
            if (bus.ex4_vld && !bus.ctrl_ex4_stall) got.push_back(bus.ex4_expnt);
            if (issued < 4 && bus.ex3_accept) begin
                set_op(bit_at(105), 1'b0, 13'(13'h300 + issued), 4'b1000, 3'd0);
                bus.ctrl_dp_ex2_inst_pipe_down = 1'b1;
                issued++;
            end else begin
                bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
            end
            if (stall_left > 0) stall_left--;
            tick();
        end
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
        bus.ctrl_ex4_stall             = 1'b0;
        chk("b2b_count", got.size(), 4);
        chk("b2b_accept_low", zero_acc, 3);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b2b_order%0d", i), (i < got.size()) ? got[i] : 13'h0,
                13'(13'h301 + i));
        tick();
        chk("b2b_no_dup", bus.ex4_vld, 1'b0);

        // ---- flush same cycle as pipe_down while EX4 holds a result ----
        set_op(bit_at(105), 1'b0, 13'h400, 4'b1000, 3'd0);
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b1;
        tick();
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
        bus.ctrl_ex4_stall             = 1'b1;
        tick();
        tick();
        chk("fl_pre_vld", bus.ex4_vld, 1'b1);
        set_op(bit_at(105), 1'b0, 13'h500, 4'b1000, 3'd0);
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b1;
        bus.rtu_vpu_flush              = 1'b1;
        #1;
        chk("fl_accept", bus.ex3_accept, 1'b1);
        tick();
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
        bus.rtu_vpu_flush              = 1'b0;
        bus.ctrl_ex4_stall             = 1'b0;
        chk("fl_ex4_vld", bus.ex4_vld, 1'b0);
        tick();
        chk("fl_ex3_dead1", bus.ex4_vld, 1'b0);
        tick();
        chk("fl_ex3_dead2", bus.ex4_vld, 1'b0);

        // ---- reset during stall with ex4_vld high ----
        set_op(bit_at(105) | bit_at(100), 1'b1, 13'h123, 4'b1000, 3'd0);
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b1;
        tick();
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
        bus.ctrl_ex4_stall             = 1'b1;
        tick();
        tick();
        chk("rs_pre_vld", bus.ex4_vld, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_vld", bus.ex4_vld, 1'b0);
        chk("rs_frac", bus.ex4_frac, 53'h0);
        chk("rs_expnt", bus.ex4_expnt, 13'h0);
        chk("rs_nx", bus.ex4_nx, 1'b0);
        chk("rs_sign", bus.ex4_sign, 1'b0);
        bus.ctrl_ex4_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rs_quiet%0d", i), bus.ex4_vld, 1'b0);
        end
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b1;
        tick();
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
        chk("rs_new_n1", bus.ex4_vld, 1'b0);
        tick();
        chk("rs_new_n2", bus.ex4_vld, 1'b1);
        chk("rs_new_expnt", bus.ex4_expnt, 13'h124);
        tick();

        // ---- randomized traffic against the reference model ----
        sb_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            bus.ctrl_ex4_stall = ($urandom_range(0, 3) == 0);
            bus.rtu_vpu_flush  = ($urandom_range(0, 39) == 0);
            #1;
            if (bus.ex3_accept && $urandom_range(0, 3) != 0) begin
                rand_op();
                bus.ctrl_dp_ex2_inst_pipe_down = 1'b1;
            end else begin
                bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
            end
            tick();
        end
        bus.ctrl_dp_ex2_inst_pipe_down = 1'b0;
        bus.ctrl_ex4_stall             = 1'b0;
        bus.rtu_vpu_flush              = 1'b0;
        repeat (4) tick();
        chk("sb_drain", exp_q.size(), 0);
        sb_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
